// File: rtl/riscv_pkg.sv
// Shared types and constants for the integer writeback slice.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } ld_size_e;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  // Size encoding 3 has no legal access width, so it is always rejected.
  function automatic logic ld_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      LD_B:    bad = 1'b0;
      LD_H:    bad = addr_lo[0];
      LD_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load aligner: picks the addressed byte/half from an aligned
// memory word and sign- or zero-extends it to XLEN.
module riscv_load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_v = word_i[7:0];
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = word_i;
    case (size_i)
      LD_B:    data_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
      LD_H:    data_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/riscv_writeback.sv
// Writeback stage: sole driver of the regfile write port. Retires ALU results
// directly and parks on loads until the memory response or a timeout.
module riscv_writeback
  import riscv_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 64,
  parameter int TO_W         = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_rd_wen_i,
  input  logic                  ex_is_load_i,
  input  logic [1:0]            ex_ld_size_i,
  input  logic                  ex_ld_unsigned_i,
  input  logic [1:0]            ex_addr_lo_i,
  input  logic [XLEN-1:0]       ex_alu_res_i,
  input  logic                  mem_rsp_valid_i,
  input  logic [XLEN-1:0]       mem_rsp_data_i,
  output logic                  rf_wr_en_o,
  output logic [REG_ADDR_W-1:0] rf_wr_addr_o,
  output logic [XLEN-1:0]       rf_wr_data_o,
  output logic                  wb_busy_o,
  output logic [REG_ADDR_W-1:0] wb_busy_rd_o,
  output logic                  ld_err_o,
  output logic [XLEN-1:0]       retire_cnt_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOAD_TIMEOUT - 1);

  wb_state_e             state_q, state_d;
  logic [TO_W-1:0]       cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic                  ld_wen_q, ld_wen_d;
  logic [1:0]            ld_size_q, ld_size_d;
  logic                  ld_uns_q, ld_uns_d;
  logic [1:0]            ld_addr_lo_q, ld_addr_lo_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic [REG_ADDR_W-1:0] busy_rd_q, busy_rd_d;
  logic                  err_q, err_d;
  logic [XLEN-1:0]       retire_q, retire_d;
  logic [XLEN-1:0]       ld_data;

  riscv_load_align u_align (
    .word_i     (mem_rsp_data_i),
    .addr_lo_i  (ld_addr_lo_q),
    .size_i     (ld_size_q),
    .unsigned_i (ld_uns_q),
    .data_o     (ld_data)
  );

  assign ex_ready_o = (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ld_rd_d      = ld_rd_q;
    ld_wen_d     = ld_wen_q;
    ld_size_d    = ld_size_q;
    ld_uns_d     = ld_uns_q;
    ld_addr_lo_d = ld_addr_lo_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    busy_rd_d    = busy_rd_q;
    err_d        = 1'b0;
    retire_d     = retire_q;

    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (!ex_is_load_i) begin
            wr_en_d   = ex_rd_wen_i & (ex_rd_i != '0);
            wr_addr_d = ex_rd_i;
            wr_data_d = ex_alu_res_i;
            retire_d  = retire_q + 32'd1;
          end else if (ld_misaligned(ex_ld_size_i, ex_addr_lo_i)) begin
            err_d    = 1'b1;
            retire_d = retire_q + 32'd1;
          end else begin
            ld_rd_d      = ex_rd_i;
            ld_wen_d     = ex_rd_wen_i;
            ld_size_d    = ex_ld_size_i;
            ld_uns_d     = ex_ld_unsigned_i;
            ld_addr_lo_d = ex_addr_lo_i;
            cnt_d        = '0;
            busy_d       = 1'b1;
            busy_rd_d    = ex_rd_i;
            state_d      = WAIT_LOAD;
          end
        end
      end
      WAIT_LOAD: begin
        cnt_d = cnt_q + 1'b1;
        // A response in the final timeout cycle still completes the load.
        if (mem_rsp_valid_i) begin
          wr_en_d   = ld_wen_q & (ld_rd_q != '0);
          wr_addr_d = ld_rd_q;
          wr_data_d = ld_data;
          retire_d  = retire_q + 32'd1;
          busy_d    = 1'b0;
          busy_rd_d = '0;
          state_d   = IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_d     = 1'b1;
          busy_d    = 1'b0;
          busy_rd_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ld_rd_q      <= '0;
      ld_wen_q     <= 1'b0;
      ld_size_q    <= 2'd0;
      ld_uns_q     <= 1'b0;
      ld_addr_lo_q <= 2'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      busy_rd_q    <= '0;
      err_q        <= 1'b0;
      retire_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ld_rd_q      <= ld_rd_d;
      ld_wen_q     <= ld_wen_d;
      ld_size_q    <= ld_size_d;
      ld_uns_q     <= ld_uns_d;
      ld_addr_lo_q <= ld_addr_lo_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      busy_rd_q    <= busy_rd_d;
      err_q        <= err_d;
      retire_q     <= retire_d;
    end
  end

  assign rf_wr_en_o   = wr_en_q;
  assign rf_wr_addr_o = wr_addr_q;
  assign rf_wr_data_o = wr_data_q;
  assign wb_busy_o    = busy_q;
  assign wb_busy_rd_o = busy_rd_q;
  assign ld_err_o     = err_q;
  assign retire_cnt_o = retire_q;

endmodule

// File: doc/riscv_writeback.md
Name: riscv_writeback

Overview:
- Writeback stage sitting directly upstream of the integer register file; it is the only driver of the regfile write port.
- Accepts completed ALU results and load requests from the execute/memory stage over a valid/ready handshake.
- Waits for the variable-latency data-memory response, extracts and extends load data, and issues registered writes.
- Provides busy/rd information for hazard checks, a load-timeout error and a retire counter.

Parameters:
- LOAD_TIMEOUT, 64, cycles to wait for mem_rsp_valid_i before abandoning a load.
- TO_W, 7, width of the timeout counter; the counter must hold LOAD_TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_valid_i  in  1  instruction presented by execute
- ex_ready_o  out  1  writeback can accept
- ex_rd_i  in  5  destination register
- ex_rd_wen_i  in  1  instruction writes rd
- ex_is_load_i  in  1  instruction is a load
- ex_ld_size_i  in  2  0=byte, 1=half, 2=word; 3 is illegal
- ex_ld_unsigned_i  in  1  zero-extend (LBU/LHU)
- ex_addr_lo_i  in  2  load address bits [1:0]
- ex_alu_res_i  in  32  ALU result
- mem_rsp_valid_i  in  1  load data valid, single-cycle pulse
- mem_rsp_data_i  in  32  aligned 32-bit memory word
- rf_wr_en_o  out  1  regfile write enable
- rf_wr_addr_o  out  5  regfile write address
- rf_wr_data_o  out  32  regfile write data
- wb_busy_o  out  1  load outstanding
- wb_busy_rd_o  out  5  rd of the outstanding load, 0 when idle
- ld_err_o  out  1  one-cycle pulse: misaligned/illegal load or timeout
- retire_cnt_o  out  32  instructions retired

Behaviour:
- Reset values:
  - State is IDLE.
  - rf_wr_en_o=0, rf_wr_addr_o=0, rf_wr_data_o=0.
  - wb_busy_o=0, wb_busy_rd_o=0, ld_err_o=0, retire_cnt_o=0.
  - Timeout counter is 0.
- All outputs are registered except ex_ready_o, which is combinational: ex_ready_o = (state==IDLE).
- FSM states: IDLE, WAIT_LOAD.
- IDLE, accept of a non-load (ex_valid_i & ex_ready_o & !ex_is_load_i) in cycle N:
  - In N+1: rf_wr_en_o = ex_rd_wen_i & (ex_rd_i!=0), rf_wr_addr_o=ex_rd_i, rf_wr_data_o=ex_alu_res_i.
  - retire_cnt_o increments in N+1, whether or not a write occurs.
- IDLE, accept of a load in cycle N:
  - Misalignment check: half with addr_lo[0]=1, word with addr_lo!=0, or size=3.
  - If misaligned: ld_err_o pulses in N+1, no write, no memory wait, retire_cnt_o increments; stay IDLE.
  - Otherwise: latch rd, rd_wen, size, unsigned and addr_lo; enter WAIT_LOAD in N+1; wb_busy_o=1 and wb_busy_rd_o=rd (rd shown even when rd=0).
- WAIT_LOAD:
  - Timeout counter increments each cycle.
  - mem_rsp_valid_i in cycle M:
    - Extract the byte at lane addr_lo, or the half at lane addr_lo[1].
    - Sign-extend, or zero-extend when unsigned; words pass through.
    - Write in M+1 (x0 and rd_wen=0 suppressed); retire_cnt_o increments.
    - State returns to IDLE in M+1; ex_ready_o is 1 from M+1.
  - Counter reaches LOAD_TIMEOUT-1 with no response: ld_err_o pulses next cycle, no write, no retire, return to IDLE.
  - A response arriving in the same cycle as the timeout is accepted; the response wins.
- mem_rsp_valid_i in IDLE is ignored; no write, no error.
- rf_wr_en_o is high for exactly one cycle per write.
- retire_cnt_o wraps modulo 2^32.
- Reset asserted mid-load abandons the load; a later response is ignored.
- ex_* inputs are sampled only on accept; their values while ex_ready_o=0 are don't-care.

Decomposition:
- Shared package riscv_pkg holds:
  - ld_size_e enum (LD_B=0, LD_H=1, LD_W=2).
  - wb_state_e (IDLE, WAIT_LOAD).
  - REG_ADDR_W=5, XLEN=32.
- One natural sub-module: riscv_load_align, purely combinational (word, addr_lo, size, unsigned) -> 32-bit extended data. The same block is reused by a future store-side aligner test.

Test Plan:
- ALU write: accept rd=5, alu=0xDEADBEEF at cycle 10 -> cycle 11 rf_wr_en_o=1, addr=5, data=0xDEADBEEF; retire_cnt_o=1.
- x0 suppression: accept rd=0, alu=0x1234 -> rf_wr_en_o stays 0; retire_cnt_o increments.
- Load byte signed: addr_lo=3, size=B, mem data 0x80FF_0000 after 4 cycles:
  - ex_ready_o=0 and wb_busy_rd_o=rd while waiting.
  - Write data 0xFFFFFF80 one cycle after the response.
  - LHU addr_lo=2 on the same word -> 0x000080FF.
- Misaligned: LW with addr_lo=2 -> ld_err_o pulse next cycle, no write, wb_busy_o stays 0.
- Timeout: LOAD_TIMEOUT=8, no response -> ld_err_o pulses once, state IDLE, no write.
  - A later mem_rsp_valid_i is ignored.
  - Response exactly at the timeout cycle -> write occurs, no error.
- Reset in WAIT_LOAD: assert reset for 1 cycle -> all outputs at reset values; next ALU accept writes normally.
